// File: rtl/log_mul_pkg.sv
// Shared definitions for the log-scale float16 multiplier front end.
// Holds the datapath widths, LUT geometry, controller state encoding and
// a few fp16 special-value constants used around the multiplier.
package log_mul_pkg;

  localparam int FLOAT_LEN = 16;
  localparam int MANT_LEN  = 10;
  localparam int LUT_SIZE  = 128;

  typedef enum logic [1:0] {
    LOAD_LOG = 2'd0,
    LOAD_EXP = 2'd1,
    RUN      = 2'd2
  } ctrl_state_e;

  localparam logic [FLOAT_LEN-1:0] FP16_QNAN = 16'h7E00;
  localparam logic [FLOAT_LEN-1:0] FP16_INF  = 16'h7C00;
  localparam logic [FLOAT_LEN-1:0] FP16_ONE  = 16'h3C00;

  // True when the given entry counter addresses the last LUT entry.
  function automatic logic is_last_entry(input logic [7:0] cnt);
    return (cnt == 8'(LUT_SIZE - 1));
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register of single-bit valid flags.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_bit      bit shifted into stage 0 every cycle
//   stages      all stage contents (stage DEPTH-1 is the oldest)
//   out_bit     oldest stage
module valid_delay_line #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  output logic [DEPTH-1:0] stages,
  output logic             out_bit
);

  logic [DEPTH-1:0] stages_q;
  logic [DEPTH-1:0] stages_d;

  // Next-state shift: new bit enters stage 0, every other stage moves up one.
  always_comb begin
    stages_d    = stages_q;
    stages_d[0] = in_bit;
    for (int i = 1; i < DEPTH; i++) begin
      stages_d[i] = stages_q[i-1];
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages_q <= '0;
    end else begin
      stages_q <= stages_d;
    end
  end

  assign stages  = stages_q;
  assign out_bit = stages_q[DEPTH-1];

endmodule

// File: rtl/log_mul_ctrl.sv
// Front-end controller for the log-scale float16 multiplier.
// After reset it streams log2/exp2 LUT entries from the config port into the
// multiplier's sequential LUT-write port (exactly LUT_SIZE write pulses), then
// accepts operand pairs every cycle and frames the multiplier's results.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_data  config word stream (log word, exp word, ...)
//   lut_loaded                 both tables fully written
//   in_valid/in_ready/in_a/in_b   operand handshake
//   out_valid/out_result       result strobe and product (zero when not valid)
//   idle                       nothing in flight
//   mul_lut_wr_en/mul_log2_data/mul_exp2_data  multiplier LUT write port
//   mul_a/mul_b/mul_result     multiplier operands and result
module log_mul_ctrl
  import log_mul_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [15:0]          cfg_data,
  output logic                 lut_loaded,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FLOAT_LEN-1:0] in_a,
  input  logic [FLOAT_LEN-1:0] in_b,
  output logic                 out_valid,
  output logic [FLOAT_LEN-1:0] out_result,
  output logic                 idle,
  output logic                 mul_lut_wr_en,
  output logic [MANT_LEN-1:0]  mul_log2_data,
  output logic [FLOAT_LEN-1:0] mul_exp2_data,
  output logic [FLOAT_LEN-1:0] mul_a,
  output logic [FLOAT_LEN-1:0] mul_b,
  input  logic [FLOAT_LEN-1:0] mul_result
);

  // One stage lines up with the mul_a/mul_b register, MUL_LAT more with the
  // multiplier pipeline, so the oldest stage is high exactly while mul_result
  // holds the matching product. The output register adds the final cycle.
  localparam int VLD_DEPTH = MUL_LAT + 1;

  ctrl_state_e            state_q, state_d;
  logic [7:0]             entry_cnt_q, entry_cnt_d;
  logic [MANT_LEN-1:0]    log_buf_q, log_buf_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   in_ready_q, in_ready_d;
  logic                   lut_loaded_q, lut_loaded_d;
  logic                   wr_en_q, wr_en_d;
  logic [MANT_LEN-1:0]    log2_data_q, log2_data_d;
  logic [FLOAT_LEN-1:0]   exp2_data_q, exp2_data_d;
  logic [FLOAT_LEN-1:0]   mul_a_q, mul_a_d;
  logic [FLOAT_LEN-1:0]   mul_b_q, mul_b_d;
  logic                   out_valid_q, out_valid_d;
  logic [FLOAT_LEN-1:0]   out_result_q, out_result_d;
  logic                   idle_q, idle_d;

  logic                   cfg_acc_s;
  logic                   in_acc_s;
  logic [VLD_DEPTH-1:0]   vld_stages_s;
  logic                   vld_last_s;

  assign cfg_acc_s = cfg_valid & cfg_ready_q;
  assign in_acc_s  = in_valid & in_ready_q;

  valid_delay_line #(
    .DEPTH (VLD_DEPTH)
  ) u_vld (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_bit (in_acc_s),
    .stages (vld_stages_s),
    .out_bit(vld_last_s)
  );

  // Next-state logic: LUT load sequencing, operand capture and result framing.
  always_comb begin
    state_d     = state_q;
    entry_cnt_d = entry_cnt_q;
    log_buf_d   = log_buf_q;
    wr_en_d     = 1'b0;
    log2_data_d = log2_data_q;
    exp2_data_d = exp2_data_q;

    case (state_q)
      LOAD_LOG: begin
        if (cfg_acc_s) begin
          log_buf_d = cfg_data[MANT_LEN-1:0];
          state_d   = LOAD_EXP;
        end else begin
          state_d = LOAD_LOG;
        end
      end
      LOAD_EXP: begin
        if (cfg_acc_s) begin
          wr_en_d     = 1'b1;
          log2_data_d = log_buf_q;
          exp2_data_d = cfg_data;
          entry_cnt_d = entry_cnt_q + 8'd1;
          if (is_last_entry(entry_cnt_q)) begin
            state_d = RUN;
          end else begin
            state_d = LOAD_LOG;
          end
        end else begin
          state_d = LOAD_EXP;
        end
      end
      RUN: begin
        // The multiplier's write pointer only clears on rst_n, so RUN is
        // terminal and the config port stays closed.
        state_d = RUN;
      end
      default: begin
        state_d = LOAD_LOG;
      end
    endcase

    if (in_acc_s) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
    end else begin
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
    end

    // Handshake flags follow the state being entered so they are registered.
    cfg_ready_d  = (state_d != RUN);
    in_ready_d   = (state_d == RUN);
    lut_loaded_d = (state_d == RUN);

    out_valid_d  = vld_last_s;
    if (vld_last_s) begin
      out_result_d = mul_result;
    end else begin
      out_result_d = {FLOAT_LEN{1'b0}};
    end

    // Idle next cycle only if no stage (including the new accept) will hold a 1.
    idle_d = ~(in_acc_s | (|vld_stages_s));
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_LOG;
      entry_cnt_q  <= 8'd0;
      log_buf_q    <= {MANT_LEN{1'b0}};
      cfg_ready_q  <= 1'b1;
      in_ready_q   <= 1'b0;
      lut_loaded_q <= 1'b0;
      wr_en_q      <= 1'b0;
      log2_data_q  <= {MANT_LEN{1'b0}};
      exp2_data_q  <= {FLOAT_LEN{1'b0}};
      mul_a_q      <= {FLOAT_LEN{1'b0}};
      mul_b_q      <= {FLOAT_LEN{1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= {FLOAT_LEN{1'b0}};
      idle_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      entry_cnt_q  <= entry_cnt_d;
      log_buf_q    <= log_buf_d;
      cfg_ready_q  <= cfg_ready_d;
      in_ready_q   <= in_ready_d;
      lut_loaded_q <= lut_loaded_d;
      wr_en_q      <= wr_en_d;
      log2_data_q  <= log2_data_d;
      exp2_data_q  <= exp2_data_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      idle_q       <= idle_d;
    end
  end

  assign cfg_ready     = cfg_ready_q;
  assign in_ready      = in_ready_q;
  assign lut_loaded    = lut_loaded_q;
  assign mul_lut_wr_en = wr_en_q;
  assign mul_log2_data = log2_data_q;
  assign mul_exp2_data = exp2_data_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign out_valid     = out_valid_q;
  assign out_result    = out_result_q;
  assign idle          = idle_q;

endmodule
